// File: rtl/snes_pad_reader_if.sv
// Pad-side and FSM-side signals of one SNES controller reader.
// master: the reader; slave: pad/FSM environment.
interface snes_pad_reader_if;
  logic        serial_data;
  logic        snes_clk;
  logic        data_latch;
  logic [11:0] buttons;
  logic [11:0] pressed;
  logic [11:0] pressed_clr;
  logic        frame_done;

  modport master (
    input  serial_data, pressed_clr,
    output snes_clk, data_latch, buttons, pressed, frame_done
  );

  modport slave (
    output serial_data, pressed_clr,
    input  snes_clk, data_latch, buttons, pressed, frame_done
  );
endinterface

// File: rtl/snes_pad_reader.sv
// Self-timed SNES pad poller: latch/clock generation, 16-bit serial capture, per-frame button state.
// Optional macro SNES_PRESS_LATCH_EN builds the sticky pressed flags; otherwise pressed reads 0.
module snes_pad_reader #(
  parameter int unsigned CLK_DIV    = 21,
  parameter int unsigned POLL_TICKS = 40000
) (
  input  logic               clk,
  input  logic               reset,
  snes_pad_reader_if.master  pad
);

  localparam int unsigned TW        = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [15:0]   POLL_LAST = 16'(POLL_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_READ, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick_cnt;
  logic [15:0]   r_poll;
  logic          r_sync1, r_sync2;
  logic          r_latch, r_sclk, r_frame_done;
  logic [15:0]   r_shift;
  logic [11:0]   r_buttons;
  logic          w_tick;
  logic          w_latch_d, w_sclk_d, w_shift_en, w_done;
  logic [11:0]   w_new;

  assign w_tick = (r_tick_cnt == TICK_LAST);
  assign w_new  = ~r_shift[11:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_tick && r_poll == 16'd0)  w_state_nxt = S_LATCH;
      S_LATCH: if (w_tick && r_poll == 16'd2)  w_state_nxt = S_READ;
      S_READ:  if (w_tick && r_poll == 16'd34) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame schedule follows the free-running poll counter: odd ticks sample and drop the clock, even ticks raise it.
  always_comb begin
    w_latch_d  = r_latch;
    w_sclk_d   = r_sclk;
    w_shift_en = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE:  if (w_tick && r_poll == 16'd0) w_latch_d = 1'b1;
      S_LATCH: if (w_tick && r_poll == 16'd2) w_latch_d = 1'b0;
      S_READ: begin
        if (w_tick) begin
          if (r_poll[0]) begin
            w_sclk_d   = 1'b0;
            w_shift_en = 1'b1;
          end else begin
            w_sclk_d   = 1'b1;
          end
        end
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= pad.serial_data;
      r_sync2 <= r_sync1;
    end
  end

  // Bits enter at the MSB so the first bit read ends up at shift[0] after 16 samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt   <= '0;
      r_poll       <= '0;
      r_latch      <= 1'b0;
      r_sclk       <= 1'b1;
      r_shift      <= '0;
      r_buttons    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) r_poll <= (r_poll == POLL_LAST) ? '0 : r_poll + 16'd1;
      r_latch      <= w_latch_d;
      r_sclk       <= w_sclk_d;
      r_frame_done <= w_done;
      if (w_shift_en) r_shift   <= {r_sync2, r_shift[15:1]};
      if (w_done)     r_buttons <= w_new;
    end
  end

`ifdef SNES_PRESS_LATCH_EN
  logic [11:0] r_pressed;
  logic [11:0] w_rise;

  assign w_rise = w_done ? (w_new & ~r_buttons) : '0;

  // A new press on the same clk as its clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) r_pressed <= '0;
    else       r_pressed <= (r_pressed | w_rise) & ~(pad.pressed_clr & ~w_rise);
  end

  assign pad.pressed = r_pressed;
`else
  assign pad.pressed = '0;
`endif

  assign pad.snes_clk   = r_sclk;
  assign pad.data_latch = r_latch;
  assign pad.buttons    = r_buttons;
  assign pad.frame_done = r_frame_done;

endmodule

// File: doc/snes_pad_reader.md
# snes_pad_reader

Self-timed SNES controller poller that generates the pad's latch and clock, shifts in the 16-bit serial report, and presents debounced-by-frame button state to the control FSM. It sits directly upstream of the FSM's button inputs, one instance per pad. It runs entirely on the system clock using a clock-enable tick, with no derived clock domain. It also keeps sticky per-button "pressed since last cleared" flags so the FSM cannot miss short taps between its polls.

## Interface
- CLK_DIV, 21: system clocks per tick; a tick is half an SNES clock period (about 1.19 MHz SNES clock at 50 MHz). Minimum 4.
- POLL_TICKS, 40000: ticks from one frame start to the next (about 60 Hz). Minimum 36, at most 65535.
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- serial_data  in  1  pad data line, asynchronous, active-low
- snes_clk  out  1  pad clock, idles high
- data_latch  out  1  pad latch, active-high
- buttons  out  12  current state, 1 = held. Bits 0–11 are B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R.
- pressed  out  12  sticky rising-edge flags, same bit order
- pressed_clr  in  12  per-bit clear for pressed
- frame_done  out  1  one-cycle pulse when buttons updates

## Operation
- Tick generator: counter 0..CLK_DIV-1. tick=1 for one clk when the counter equals CLK_DIV-1, then the counter wraps to 0.
- serial_data passes through a 2-flop synchronizer before any use.
- States:
  - IDLE: waits until the poll counter reaches 0 on a tick, then goes to LATCH.
  - LATCH: data_latch=1 for 2 ticks.
  - READ: 16 bits, each taking 2 ticks.
  - DONE: 1 clk, then back to IDLE.
- Poll counter: counts ticks 0..POLL_TICKS-1 and wraps. It runs in every state, so frame period is exactly POLL_TICKS ticks.
- Frame tick schedule, where tick n is relative to frame start:
  - n=0: data_latch rises.
  - n=2: data_latch falls.
  - n=3+2i (i=0..15): shift[i] ← synchronized serial_data, and snes_clk falls.
  - n=4+2i: snes_clk rises.
- At tick 34 the FSM enters DONE. The next clk performs:
  - buttons ← ~shift[11:0]; shift[15:12] is discarded.
  - pressed ← (pressed | (new & ~old)) & ~(pressed_clr & ~(new & ~old)), where new is the incoming buttons value and old is the previous buttons value.
  - frame_done=1.
- Outside DONE: pressed ← pressed & ~pressed_clr.
- Simultaneous set and clear on the same bit: set wins.
- Pad unplugged: serial_data floats or pulls high, so it reads as all released (buttons=0).

## Timing
- Reset values: snes_clk=1, data_latch=0, buttons=0, pressed=0, frame_done=0. Tick counter, poll counter and shift register clear to 0; state=IDLE.
- First frame: data_latch rises on the first tick after reset deasserts, i.e. CLK_DIV clks later.
- Output changes: snes_clk and data_latch are registered and change on the clk edge where the tick fires.
- Latency: buttons and frame_done become valid 34·CLK_DIV+1 clks after data_latch rises.
- buttons is stable between frame_done pulses.
- frame_done period: exactly POLL_TICKS·CLK_DIV clks.
- Reset mid-frame: the frame aborts immediately. Outputs take reset values the next clk, and buttons/pressed are not updated from the partial shift.
- pressed_clr is honoured every clk; a cleared bit reads 0 on the following clk.

## Configuration
- SNES_PRESS_LATCH_EN defined: the pressed register and pressed_clr logic are built as described above.
- SNES_PRESS_LATCH_EN undefined: pressed is tied to 12'b0 and pressed_clr is ignored. buttons, frame_done and all pad timing are unchanged.

## Test plan
All scenarios use CLK_DIV=4 and POLL_TICKS=40, with SNES_PRESS_LATCH_EN defined unless stated otherwise.
- Reset, then release: snes_clk=1 and data_latch=0 during reset. data_latch rises 4 clks after release and is high for 8 clks. Exactly 16 snes_clk low pulses of 4 clks each follow. frame_done pulses 137 clks after the latch rise.
- Pad model drives the active-low report 16'hFEFE (A and B held): buttons=12'h101 after frame_done. The next frame_done arrives exactly 160 clks later.
- Press Start for one frame with pressed_clr=0: pressed[3]=1 and stays 1 after Start is released. Pulse pressed_clr[3]: pressed[3]=0 on the next clk.
- pressed_clr[8]=1 held through the DONE cycle in which A is newly pressed: pressed[8]=1 (set wins).
- Assert reset at frame tick 20: data_latch=0 and snes_clk=1 next clk, buttons=0. After release a full frame runs from tick 0 with no partial update.
- Build without SNES_PRESS_LATCH_EN and repeat the Start scenario: pressed=0 throughout, buttons identical to the defined build.
